hex_display_sched: RTL and testbench
====================================

# hex_display_sched

Time-shares the six board seven-segment digits (HEX5..HEX0) between several producers, such as a frame counter, the edge threshold and debug status. Each producer offers a 24-bit value (six hex nibbles) on a valid/ready handshake. A round-robin scheduler grants one owner at a time, holds the display for a fixed dwell period, then rotates. The block decodes the granted value to active-low segment patterns and registers them for the top level, which drives the HEX pins.

## Interface
Parameters:
- NUM_REQ, 3: number of requesters, range 1..4.
- DWELL_CYCLES, 50_000_000: cycles each grant holds the display (1 s at 50 MHz), must be ≥ 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a value to show.
- req_value  in  24*NUM_REQ  requester i value in bits [24i+23:24i]; nibble k goes to HEXk.
- req_ready  out  NUM_REQ  handshake accept; at most one bit high.
- owner  out  2  index of the current display owner.
- busy  out  1  high while in DWELL.
- hex  out  48  registered segment patterns, HEXk in bits [8k+7:8k].
  - Bit 7 is the decimal point and is always 1 (off).
  - Bits 6..0 are segments g..a, active-low.

## Operation
- Glyphs for 0–F: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, B=83, C=C6, D=A1, E=86, F=8E. Blank is FF.
- FSM has two states, IDLE and DWELL.
- IDLE behaviour:
  - Combinationally pick the first requester with req_valid set, searching from (last+1) mod NUM_REQ and wrapping.
  - Assert req_ready for that requester only.
  - If no requester is valid, all req_ready bits are 0 and the display holds its current contents indefinitely.
- Handshake: the transfer occurs on a rising edge where req_valid[i] & req_ready[i] are both high. On that edge:
  - the decoded value loads into hex;
  - owner and last take the value i;
  - the dwell counter loads DWELL_CYCLES-1;
  - the FSM moves to DWELL.
- DWELL behaviour:
  - req_ready[owner] = req_valid[owner]; all other ready bits are 0.
  - An owner handshake refreshes hex only. It does not restart the counter.
  - The counter decrements every cycle. When it is 0, the FSM returns to IDLE on the next edge.
  - Non-owners wait. They hold req_valid and req_value stable until they are accepted.
- Rotation is fair: with all requesters continuously valid, grants go 0,1,…,NUM_REQ-1,0,…
- NUM_REQ=1: the single requester is re-granted after every dwell.
- Dropping req_valid mid-dwell has no effect on the grant or the counter.
- The counter width is $clog2(DWELL_CYCLES+1). It never underflows.

## Timing
- Reset values:
  - hex = all FF (every digit blank);
  - owner = 0 and last = NUM_REQ-1, so requester 0 is searched first after reset;
  - busy = 0, state = IDLE, counter = 0;
  - req_ready then follows the IDLE rule from the first post-reset cycle.
- Latency: hex reflects accepted data on the same edge that completes the handshake. It is visible one cycle after valid&ready is sampled.
- Dwell: busy is high for exactly DWELL_CYCLES cycles per grant.
  - IDLE lasts at least 1 cycle.
  - Minimum owner-to-owner period is DWELL_CYCLES+1 cycles.
- If reset is asserted during DWELL, it wins over any simultaneous handshake or counter expiry. All state returns to reset values on that edge.

## Configuration
- HEX_LZB_EN defined: leading-zero blanking.
  - Scanning from HEX5 downward, each digit whose nibble is 0 is blanked (FF) until the first nonzero nibble.
  - HEX0 always displays, so a value of 0 shows "0".
  - Applies to both grant loads and in-dwell refreshes.
- HEX_LZB_EN undefined: all six digits always display their glyphs, including leading zeros.

## Test plan
- Reset: assert reset for 2 cycles with requesters idle → hex = all FF, owner=0, busy=0, req_ready=0.
- Single grant: DWELL_CYCLES=4, req0 valid with 24'h123456 → req_ready[0] high in IDLE. The next edge gives hex5..0 = F9,A4,B0,99,92,82, busy high for exactly 4 cycles, then IDLE.
- Round-robin: req0, req1 and req2 all continuously valid, DWELL_CYCLES=4 → owner sequence 0,1,2,0, one grant every 5 cycles. Non-owner ready bits stay 0 throughout DWELL.
- In-dwell update: owner changes value from 24'h000001 to 24'h000002 at dwell cycle 2 → hex0 goes F9 then A4. busy still falls exactly 4 cycles after the grant.
- Blanking: value 24'h0000A0.
  - With HEX_LZB_EN: hex5..2 = FF, hex1=88, hex0=C0.
  - Without HEX_LZB_EN: hex5..2 = C0.
  - With HEX_LZB_EN and value 0: only hex0=C0.
- Reset mid-dwell: assert reset at dwell cycle 2 while req1 is valid → the next edge gives reset values. Requester 0 (if valid) is granted before req1.

Source files
------------

// File: rtl/hex_display_sched.sv
// Round-robin owner of the six HEX digits; decodes the granted value.
// Build option: HEX_LZB_EN enables leading-zero blanking.
module hex_display_sched #(
   parameter int NUM_REQ      = 3,
   parameter int DWELL_CYCLES = 50_000_000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [24*NUM_REQ-1:0] req_value,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [1:0]            owner,
   output logic                  busy,
   output logic [47:0]           hex
);

   localparam int CW = $clog2(DWELL_CYCLES + 1);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_DWELL = 1'b1;

   localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL_CYCLES - 1);
   localparam logic [1:0]    LAST_RST = 2'(NUM_REQ - 1);

   logic [0:0]         state;
   logic [CW-1:0]      cnt;
   logic [1:0]         last;
   logic [NUM_REQ-1:0] ready_c;
   logic               sel_hit;
   logic [1:0]         sel_idx;
   logic [23:0]        sel_val;
   int                 idx;

   function automatic logic [7:0] glyph(input logic [3:0] n);
      logic [7:0] g;
      case (n)
         4'h0:    g = 8'hC0;
         4'h1:    g = 8'hF9;
         4'h2:    g = 8'hA4;
         4'h3:    g = 8'hB0;
         4'h4:    g = 8'h99;
         4'h5:    g = 8'h92;
         4'h6:    g = 8'h82;
         4'h7:    g = 8'hF8;
         4'h8:    g = 8'h80;
         4'h9:    g = 8'h90;
         4'hA:    g = 8'h88;
         4'hB:    g = 8'h83;
         4'hC:    g = 8'hC6;
         4'hD:    g = 8'hA1;
         4'hE:    g = 8'h86;
         default: g = 8'h8E;
      endcase
      return g;
   endfunction

   function automatic logic [47:0] decode(input logic [23:0] v);
      logic [47:0] r;
`ifdef HEX_LZB_EN
      logic lead;
      lead = 1'b1;
`endif
      r = '0;
      for (int k = 5; k >= 0; k--) begin
`ifdef HEX_LZB_EN
         // HEX0 is never blanked so a zero value still reads "0"
         if (lead && k != 0 && v[4*k +: 4] == 4'h0) begin
            r[8*k +: 8] = 8'hFF;
         end else begin
            lead        = 1'b0;
            r[8*k +: 8] = glyph(v[4*k +: 4]);
         end
`else
         r[8*k +: 8] = glyph(v[4*k +: 4]);
`endif
      end
      return r;
   endfunction

   // Select who may hand off: rotating search in IDLE, owner only in DWELL
   always_comb begin
      ready_c = '0;
      sel_hit = 1'b0;
      sel_idx = '0;
      sel_val = '0;
      idx     = 0;
      if (state == S_IDLE) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(last) + 1 + k) % NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
               if (!sel_hit && i == idx && req_valid[i]) begin
                  sel_hit    = 1'b1;
                  sel_idx    = 2'(i);
                  sel_val    = req_value[24*i +: 24];
                  ready_c[i] = 1'b1;
               end
            end
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (2'(i) == owner) begin
               ready_c[i] = req_valid[i];
               sel_hit    = req_valid[i];
               sel_idx    = owner;
               sel_val    = req_value[24*i +: 24];
            end
         end
      end
   end

   assign req_ready = ready_c;
   assign busy      = (state == S_DWELL);

   // Grant/dwell sequencing and the registered segment outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         last  <= LAST_RST;
         owner <= 2'd0;
         hex   <= {48{1'b1}};
      end else begin
         case (state)
            S_IDLE: begin
               if (sel_hit) begin
                  hex   <= decode(sel_val);
                  owner <= sel_idx;
                  last  <= sel_idx;
                  cnt   <= CNT_LOAD;
                  state <= S_DWELL;
               end
            end
            default: begin
               // owner refreshes update the digits but never extend the dwell
               if (sel_hit) begin
                  hex <= decode(sel_val);
               end
               if (cnt == '0) begin
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hex_display_sched.sv
// Bench for hex_display_sched: grant scoreboard plus directed timing checks.
// Honours HEX_LZB_EN when choosing expected blanked patterns.
module tb_hex_display_sched;

   localparam int NR = 3;
   localparam int DW = 4;

   localparam logic [47:0] H_BLANK  = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] H_123456 = 48'hF9A4_B099_9282;
   localparam logic [47:0] H_ABCDEF = 48'h8883_C6A1_868E;
   localparam logic [47:0] H_987654 = 48'h9080_F882_9299;
   localparam logic [47:0] H_10F0E0 = 48'hF9C0_8EC0_86C0;
`ifdef HEX_LZB_EN
   localparam logic [47:0] H_000001 = 48'hFFFF_FFFF_FFF9;
   localparam logic [47:0] H_000002 = 48'hFFFF_FFFF_FFA4;
   localparam logic [47:0] H_0000A0 = 48'hFFFF_FFFF_88C0;
   localparam logic [47:0] H_000000 = 48'hFFFF_FFFF_FFC0;
`else
   localparam logic [47:0] H_000001 = 48'hC0C0_C0C0_C0F9;
   localparam logic [47:0] H_000002 = 48'hC0C0_C0C0_C0A4;
   localparam logic [47:0] H_0000A0 = 48'hC0C0_C0C0_88C0;
   localparam logic [47:0] H_000000 = 48'hC0C0_C0C0_C0C0;
`endif

   typedef struct {
      logic [47:0] hex;
      logic [1:0]  owner;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset;
   logic [NR-1:0]    req_valid;
   logic [24*NR-1:0] req_value;
   logic [NR-1:0]    req_ready;
   logic [1:0]       owner;
   logic             busy;
   logic [47:0]      hex;

   int   total = 0;
   int   bad   = 0;
   exp_t q[$];

   hex_display_sched #(.NUM_REQ(NR), .DWELL_CYCLES(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_value (req_value),
      .req_ready (req_ready),
      .owner     (owner),
      .busy      (busy),
      .hex       (hex)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [47:0] act,
                        input logic [47:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [47:0] h, input logic [1:0] o);
      exp_t e;
      e.hex   = h;
      e.owner = o;
      q.push_back(e);
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while (busy && n < 20) begin
         n++;
         @(negedge clk);
      end
      check(nm, {47'd0, busy}, 48'd0);
   endtask

   task automatic grant_one(input int i, input logic [23:0] v,
                            input logic [47:0] eh, input string nm);
      @(negedge clk);
      req_value[24*i +: 24] = v;
      req_valid[i]          = 1'b1;
      push(eh, 2'(i));
      @(negedge clk);
      req_valid = '0;
      wait_idle(nm);
   endtask

   // Scoreboard monitor: every IDLE grant must match the next queued entry
   always @(posedge clk) begin
      logic g;
      exp_t e;
      g = !reset && !busy && |(req_valid & req_ready);
      #1;
      if (g) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got owner %0d hex %h want none",
                     owner, hex);
         end else begin
            e = q.pop_front();
            if (hex !== e.hex || owner !== e.owner) begin
               bad++;
               $display("FAIL sb_grant: got %0d/%h want %0d/%h",
                        owner, hex, e.owner, e.hex);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset     = 1'b1;
      req_valid = '0;
      req_value = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_hex", hex, H_BLANK);
      check("rst_owner", {46'd0, owner}, 48'd0);
      check("rst_busy", {47'd0, busy}, 48'd0);
      check("rst_ready", {45'd0, req_ready}, 48'd0);
      reset = 1'b0;

      // single grant
      @(negedge clk);
      req_value[23:0] = 24'h123456;
      req_valid       = 3'b001;
      push(H_123456, 2'd0);
      #1;
      check("sg_ready", {45'd0, req_ready}, 48'd1);
      @(negedge clk);
      req_valid = '0;
      n = 0;
      while (busy && n < 20) begin
         n++;
         @(negedge clk);
      end
      check("sg_busy_len", 48'(n), 48'd4);

      // round robin from a fresh reset
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      req_value = {24'h10F0E0, 24'h987654, 24'hABCDEF};
      req_valid = 3'b111;
      push(H_ABCDEF, 2'd0);
      push(H_987654, 2'd1);
      push(H_10F0E0, 2'd2);
      push(H_ABCDEF, 2'd0);
      for (int g = 0; g < 4; g++) begin
         logic [2:0] oh;
         oh = 3'b001 << (g % 3);
         #1;
         check("rr_idle_ready", {45'd0, req_ready}, {45'd0, oh});
         check("rr_idle_busy", {47'd0, busy}, 48'd0);
         @(negedge clk);
         for (int c = 0; c < DW; c++) begin
            check("rr_dwell_busy", {47'd0, busy}, 48'd1);
            check("rr_dwell_ready", {45'd0, req_ready}, {45'd0, oh});
            @(negedge clk);
         end
      end
      req_valid = '0;

      // in-dwell refresh
      @(negedge clk);
      req_value[23:0] = 24'h000001;
      req_valid       = 3'b001;
      push(H_000001, 2'd0);
      @(negedge clk);
      check("upd_hex1", hex, H_000001);
      check("upd_busy1", {47'd0, busy}, 48'd1);
      req_value[23:0] = 24'h000002;
      @(negedge clk);
      check("upd_hex2", hex, H_000002);
      check("upd_busy2", {47'd0, busy}, 48'd1);
      @(negedge clk);
      check("upd_busy3", {47'd0, busy}, 48'd1);
      @(negedge clk);
      check("upd_busy4", {47'd0, busy}, 48'd1);
      @(negedge clk);
      check("upd_busy_fall", {47'd0, busy}, 48'd0);
      req_valid = '0;

      // blanking patterns
      grant_one(0, 24'h0000A0, H_0000A0, "blank_a0_idle");
      grant_one(0, 24'h000000, H_000000, "blank_zero_idle");

      // reset in the middle of a dwell
      @(negedge clk);
      req_value = {24'h0, 24'h987654, 24'hABCDEF};
      req_valid = 3'b010;
      push(H_987654, 2'd1);
      @(negedge clk);
      @(negedge clk);
      reset     = 1'b1;
      req_valid = 3'b011;
      @(negedge clk);
      check("mrst_hex", hex, H_BLANK);
      check("mrst_owner", {46'd0, owner}, 48'd0);
      check("mrst_busy", {47'd0, busy}, 48'd0);
      reset = 1'b0;
      push(H_ABCDEF, 2'd0);
      #1;
      check("mrst_ready", {45'd0, req_ready}, 48'd1);
      @(negedge clk);
      req_valid = 3'b010;
      push(H_987654, 2'd1);
      wait_idle("mrst_req0_done");
      @(negedge clk);
      req_valid = '0;
      wait_idle("mrst_req1_done");
      repeat (2) @(negedge clk);

      check("sb_drained", 48'(q.size()), 48'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
